instr_cache_refill_ctlr: RTL and testbench

- Memory-side responder to the L1 instruction cache miss signalling.
- On a qualified fetch miss it captures the miss address and issues a block-aligned burst read to the instruction memory port.
- Streams the returned words into the missing line of l1_icache, then pulses completion so the cache sets the line valid and fetch resumes.
- Sits between instr_cache_ctlr/l1_icache and the instruction memory interface.

---
 rtl/instr_cache_refill_ctlr_pkg.sv | 21 ++
 rtl/instr_cache_refill_ctlr_beat_reg.sv | 59 +++++
 rtl/instr_cache_refill_ctlr.sv | 116 +++++++++++
 tb/tb_instr_cache_refill_ctlr.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_refill_ctlr_pkg.sv
// Shared types and default geometry for the instruction-cache refill path.
package instr_cache_refill_ctlr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  localparam int unsigned S_DEF     = 64;
  localparam int unsigned B_DEF     = 64;
  localparam int unsigned WIDTH_DEF = 32;

  localparam int unsigned WORDS_DEF = B_DEF / 4;
  localparam int unsigned OFF_W_DEF = $clog2(B_DEF);
  localparam int unsigned SET_W_DEF = $clog2(S_DEF);
  localparam int unsigned TAG_W_DEF = WIDTH_DEF - SET_W_DEF - OFF_W_DEF;
  localparam int unsigned IDX_W_DEF = $clog2(WORDS_DEF);

endpackage

// File: rtl/instr_cache_refill_ctlr_beat_reg.sv
// Beat capture register with a wrapping word counter; one-cycle write latency per beat.
module refill_beat_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     valid_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     we_o,
  output logic [$clog2(WORDS)-1:0] idx_o,
  output logic [WIDTH-1:0]         data_o,
  output logic                     last_o
);

  localparam int unsigned IDX_W = $clog2(WORDS);

  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             we_q, we_d;

  assign last_o = valid_i && (cnt_q == IDX_W'(WORDS - 1));

  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    data_d = data_q;
    we_d   = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (valid_i) begin
      we_d   = 1'b1;
      idx_d  = cnt_q;
      data_d = data_i;
      cnt_d  = last_o ? '0 : cnt_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      we_q   <= we_d;
    end
  end

  assign we_o   = we_q;
  assign idx_o  = idx_q;
  assign data_o = data_q;

endmodule

// File: rtl/instr_cache_refill_ctlr.sv
// Refill controller: latches a qualified fetch miss, issues one burst read and streams it into the line.
module instr_cache_refill_ctlr
  import instr_cache_refill_ctlr_pkg::*;
#(
  parameter int unsigned S     = S_DEF,
  parameter int unsigned B     = B_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  instr_miss_f_i,
  input  logic                                  instr_cache_rep_active_i,
  input  logic [WIDTH-1:0]                      pc_f_i,
  output logic                                  mem_req_o,
  output logic [WIDTH-1:0]                      mem_addr_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [WIDTH-1:0]                      mem_rdata_i,
  output logic                                  rep_we_o,
  output logic [$clog2(B/4)-1:0]                rep_word_idx_o,
  output logic [WIDTH-1:0]                      rep_data_o,
  output logic [$clog2(S)-1:0]                  rep_set_o,
  output logic [WIDTH-$clog2(S)-$clog2(B)-1:0]  rep_tag_o,
  output logic                                  rep_done_o,
  output logic                                  refill_busy_o
);

  localparam int unsigned WORDS = B / 4;
  localparam int unsigned OFF_W = $clog2(B);
  localparam int unsigned SET_W = $clog2(S);
  localparam int unsigned TAG_W = WIDTH - SET_W - OFF_W;

  refill_state_t    state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic beat_valid;
  logic beat_clear;
  logic beat_last;

  // Beats only count while filling; stray rvalid in other states is dropped here.
  assign beat_valid = mem_rvalid_i && (state_q == FILL);
  assign beat_clear = (state_q == IDLE);

  refill_beat_reg #(
    .WIDTH (WIDTH),
    .WORDS (WORDS)
  ) u_beat_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (beat_clear),
    .valid_i (beat_valid),
    .data_i  (mem_rdata_i),
    .we_o    (rep_we_o),
    .idx_o   (rep_word_idx_o),
    .data_o  (rep_data_o),
    .last_o  (beat_last)
  );

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (instr_miss_f_i && instr_cache_rep_active_i) begin
          state_d = REQ;
          set_d   = pc_f_i[OFF_W +: SET_W];
          tag_d   = pc_f_i[WIDTH-1 -: TAG_W];
          addr_d  = pc_f_i & ~WIDTH'(B - 1);
        end
      end
      REQ:     if (mem_gnt_i) state_d = FILL;
      FILL:    if (beat_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_addr_o    = addr_q;
  assign rep_set_o     = set_q;
  assign rep_tag_o     = tag_q;
  assign rep_done_o    = done_q;
  assign refill_busy_o = busy_q;

endmodule

// File: tb/tb_instr_cache_refill_ctlr.sv
// Directed and random stimulus for the refill controller, checked every cycle against a line-level model.
module tb_instr_cache_refill_ctlr;

  localparam int unsigned S     = 64;
  localparam int unsigned B     = 64;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned W     = B / 4;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        instr_miss_f_i;
  logic        instr_cache_rep_active_i;
  logic [31:0] pc_f_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rep_we_o;
  logic [3:0]  rep_word_idx_o;
  logic [31:0] rep_data_o;
  logic [5:0]  rep_set_o;
  logic [19:0] rep_tag_o;
  logic        rep_done_o;
  logic        refill_busy_o;

  instr_cache_refill_ctlr #(
    .S     (S),
    .B     (B),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i                    (clk_i),
    .reset_i                  (reset_i),
    .instr_miss_f_i           (instr_miss_f_i),
    .instr_cache_rep_active_i (instr_cache_rep_active_i),
    .pc_f_i                   (pc_f_i),
    .mem_req_o                (mem_req_o),
    .mem_addr_o               (mem_addr_o),
    .mem_gnt_i                (mem_gnt_i),
    .mem_rvalid_i             (mem_rvalid_i),
    .mem_rdata_i              (mem_rdata_i),
    .rep_we_o                 (rep_we_o),
    .rep_word_idx_o           (rep_word_idx_o),
    .rep_data_o               (rep_data_o),
    .rep_set_o                (rep_set_o),
    .rep_tag_o                (rep_tag_o),
    .rep_done_o               (rep_done_o),
    .refill_busy_o            (refill_busy_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level model: one outstanding line, a beat count, and the word to write next cycle.
  bit          m_active, m_granted;
  int unsigned m_beats;
  logic [31:0] m_addr, m_set, m_tag;
  bit          exp_we, exp_done;
  logic [31:0] exp_idx, exp_data;

  int unsigned we_cnt = 0, done_cnt = 0;
  logic [31:0] last_idx = 0, last_data = 0, done_idx = 0;

  initial begin
    forever begin
      @(posedge clk_i);
      exp_we   = 1'b0;
      exp_done = 1'b0;
      if (!reset_i) begin
        m_active = 0; m_granted = 0; m_beats = 0;
        m_addr = 0; m_set = 0; m_tag = 0;
        exp_idx = 0; exp_data = 0;
      end else if (!m_active) begin
        if (instr_miss_f_i && instr_cache_rep_active_i) begin
          m_active  = 1;
          m_granted = 0;
          m_beats   = 0;
          m_addr    = (pc_f_i / B) * B;
          m_set     = (pc_f_i / B) % S;
          m_tag     = pc_f_i / (B * S);
        end
      end else if (!m_granted) begin
        if (mem_gnt_i) m_granted = 1;
      end else if (m_beats == W) begin
        m_active = 0;
      end else if (mem_rvalid_i) begin
        exp_we   = 1'b1;
        exp_idx  = m_beats;
        exp_data = mem_rdata_i;
        m_beats++;
        exp_done = (m_beats == W);
      end
      #1;
      chk("mem_req",  {31'b0, mem_req_o},     {31'b0, m_active && !m_granted});
      chk("busy",     {31'b0, refill_busy_o}, {31'b0, m_active});
      chk("rep_we",   {31'b0, rep_we_o},      {31'b0, exp_we});
      chk("rep_done", {31'b0, rep_done_o},    {31'b0, exp_done});
      chk("mem_addr", mem_addr_o,             m_addr);
      chk("rep_set",  {26'b0, rep_set_o},     m_set);
      chk("rep_tag",  {12'b0, rep_tag_o},     m_tag);
      if (exp_we) begin
        chk("rep_idx",  {28'b0, rep_word_idx_o}, exp_idx);
        chk("rep_data", rep_data_o,              exp_data);
      end
      if (rep_we_o) begin
        we_cnt++;
        last_idx  = {28'b0, rep_word_idx_o};
        last_data = rep_data_o;
      end
      if (rep_done_o) begin
        done_cnt++;
        done_idx = {28'b0, rep_word_idx_o};
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle_inputs();
    instr_miss_f_i = 0; instr_cache_rep_active_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0;
  endtask

  task automatic start_miss(input logic [31:0] pc);
    pc_f_i = pc; instr_miss_f_i = 1; instr_cache_rep_active_i = 1;
    cyc();
    instr_miss_f_i = 0; instr_cache_rep_active_i = 0;
  endtask

  task automatic grant_now();
    mem_gnt_i = 1;
    cyc();
    mem_gnt_i = 0;
  endtask

  int unsigned we0, done0;

  initial begin
    reset_i = 0; pc_f_i = 0; mem_rdata_i = 0;
    idle_inputs();
    cyc(); cyc();
    chk("reset_req",  {31'b0, mem_req_o}, 0);
    chk("reset_busy", {31'b0, refill_busy_o}, 0);
    chk("reset_addr", mem_addr_o, 0);
    reset_i = 1;
    cyc();

    // Basic refill with a three-cycle grant delay and back-to-back beats.
    start_miss(32'h0000_1A48);
    chk("basic_addr",  mem_addr_o, 32'h0000_1A40);
    chk("basic_set",   {26'b0, rep_set_o}, 32'h29);
    chk("basic_tag",   {12'b0, rep_tag_o}, 32'h1);
    chk("model_addr",  m_addr, 32'h0000_1A40);
    chk("model_set",   m_set, 32'h29);
    cyc(); cyc();
    chk("basic_req_held", {31'b0, mem_req_o}, 1);
    grant_now();
    we0 = we_cnt; done0 = done_cnt;
    for (int i = 0; i < int'(W); i++) begin
      mem_rvalid_i = 1; mem_rdata_i = 32'h100 + 32'(i);
      cyc();
    end
    mem_rvalid_i = 0;
    cyc(); cyc();
    chk("basic_we_count",   we_cnt - we0, 16);
    chk("basic_done_count", done_cnt - done0, 1);
    chk("basic_done_idx",   done_idx, 15);
    chk("basic_last_data",  last_data, 32'h10F);

    // Miss without replacement permission must not start anything.
    for (int i = 0; i < 10; i++) begin
      pc_f_i = 32'h0000_5000 + 32'(i * 64);
      instr_miss_f_i = 1; instr_cache_rep_active_i = 0;
      cyc();
      chk("nq_req",  {31'b0, mem_req_o}, 0);
      chk("nq_busy", {31'b0, refill_busy_o}, 0);
    end
    idle_inputs();
    cyc();

    // Same-cycle grant, gapped beats, and miss/pc noise during the fill.
    pc_f_i = 32'h0000_1A48; instr_miss_f_i = 1; instr_cache_rep_active_i = 1;
    cyc();
    instr_miss_f_i = 0; instr_cache_rep_active_i = 0;
    grant_now();
    chk("gap_busy", {31'b0, refill_busy_o}, 1);
    we0 = we_cnt; done0 = done_cnt;
    for (int i = 0; i < int'(W); i++) begin
      mem_rvalid_i = 1; mem_rdata_i = $urandom;
      pc_f_i = 32'h0000_2000; instr_miss_f_i = 1'($urandom); instr_cache_rep_active_i = 1;
      cyc();
      mem_rvalid_i = 0; instr_miss_f_i = 0; instr_cache_rep_active_i = 0;
      chk("gap_we", {31'b0, rep_we_o}, 1);
      chk("gap_idx", {28'b0, rep_word_idx_o}, 32'(i));
      chk("gap_addr_hold", mem_addr_o, 32'h0000_1A40);
      chk("gap_set_hold", {26'b0, rep_set_o}, 32'h29);
      cyc();
      if (i != int'(W) - 1) chk("gap_no_write", {31'b0, rep_we_o}, 0);
      cyc();
    end
    pc_f_i = 0;
    chk("gap_we_count", we_cnt - we0, 16);
    chk("gap_done_count", done_cnt - done0, 1);

    // Reset asserted after beat 7 kills the refill immediately.
    start_miss(32'h0000_0540);
    grant_now();
    done0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      mem_rvalid_i = 1; mem_rdata_i = 32'hA000 + 32'(i);
      cyc();
    end
    mem_rvalid_i = 0;
    chk("pre_reset_idx", {28'b0, rep_word_idx_o}, 7);
    #1 reset_i = 0;
    #1;
    chk("rst_we",   {31'b0, rep_we_o}, 0);
    chk("rst_busy", {31'b0, refill_busy_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_set",  {26'b0, rep_set_o}, 0);
    chk("rst_tag",  {12'b0, rep_tag_o}, 0);
    chk("rst_idx",  {28'b0, rep_word_idx_o}, 0);
    chk("rst_data", rep_data_o, 0);
    cyc();
    reset_i = 1;
    cyc();
    chk("rst_no_done", done_cnt - done0, 0);
    start_miss(32'h0000_4000);
    grant_now();
    mem_rvalid_i = 1; mem_rdata_i = 32'hBEEF;
    cyc();
    chk("restart_we",  {31'b0, rep_we_o}, 1);
    chk("restart_idx", {28'b0, rep_word_idx_o}, 0);
    for (int i = 1; i < int'(W); i++) begin
      mem_rdata_i = 32'hB000 + 32'(i);
      cyc();
    end
    mem_rvalid_i = 0;

    // Back-to-back: miss presented during DONE and held into the first IDLE cycle.
    pc_f_i = 32'h0000_3000; instr_miss_f_i = 1; instr_cache_rep_active_i = 1;
    cyc();
    chk("b2b_idle_req", {31'b0, mem_req_o}, 0);
    cyc();
    instr_miss_f_i = 0; instr_cache_rep_active_i = 0;
    chk("b2b_req",  {31'b0, mem_req_o}, 1);
    chk("b2b_addr", mem_addr_o, 32'h0000_3000);
    chk("b2b_set",  {26'b0, rep_set_o}, 0);
    grant_now();
    mem_rvalid_i = 1;
    for (int i = 0; i < int'(W); i++) begin
      mem_rdata_i = $urandom;
      cyc();
    end
    mem_rvalid_i = 0;
    cyc(); cyc();

    // Random traffic with occasional resets; the per-cycle model does the checking.
    for (int i = 0; i < 4000; i++) begin
      instr_miss_f_i           = ($urandom % 3) != 0;
      instr_cache_rep_active_i = 1'($urandom);
      pc_f_i                   = $urandom;
      mem_gnt_i                = ($urandom % 3) == 0;
      mem_rvalid_i             = ($urandom % 4) != 0;
      mem_rdata_i              = $urandom;
      reset_i                  = ($urandom % 400) != 0;
      cyc();
    end
    reset_i = 1;
    idle_inputs();
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
